key_schedule_iter: RTL
======================

# key_schedule_iter

Iterative, runtime-configurable AES key schedule supporting AES-128/192/256 from one instance. Generates one expanded word per cycle through a single shared 4-byte S-box and stores all words in an internal register file. A random-access round-key read port feeds the cipher datapath. Sits between the key-load interface and the AES round engine, replacing fully unrolled combinational expansion where area matters.

## Interface
- MAX_LEN_KEY, 256: largest supported key length (128, 192 or 256); sizes the key bus and storage.
- NUM_WORD_MAX, derived: 4*(Nr_max+1), giving 44, 52 or 60 words.
- clk  in  1  clock. One clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- key_valid  in  1  new key presented.
- key_ready  out  1  block can accept a key.
- key_len  in  2  0=AES-128, 1=AES-192, 2=AES-256, 3=illegal.
- key_in  in  MAX_LEN_KEY  key, MSB-aligned: w0 = key_in[MAX_LEN_KEY-1 -: 32].
- keys_valid  out  1  all round keys for the current key are stored.
- err  out  1  last accepted key_len was illegal or exceeded MAX_LEN_KEY.
- nr  out  4  round count of the stored schedule: 10, 12 or 14.
- rk_idx  in  4  round-key index for reading.
- rk_out  out  128  {w[4*rk_idx], w[4*rk_idx+1], w[4*rk_idx+2], w[4*rk_idx+3]}, first word at the MSBs.

## Operation
- Nk = 4, 6 or 8 and Nr = 10, 12 or 14, selected by key_len and latched at handshake.
- Handshake: a key is accepted on an edge where key_valid & key_ready.
- FSM states: IDLE, EXPAND, DONE.
  - IDLE → EXPAND on handshake with a legal key_len.
  - IDLE/DONE → IDLE with err=1 on handshake with an illegal key_len.
  - EXPAND → DONE after word 4*(Nr+1)-1 is written.
  - DONE → EXPAND on a new legal handshake (rekey).
- key_ready = 1 in IDLE and DONE, 0 in EXPAND.
- On a legal handshake:
  - Words w0..w[Nk-1] are written from key_in in parallel.
  - Index i ← Nk, rcon ← 8'h01, nr and Nk are latched.
  - err ← 0 and keys_valid ← 0.
- Per EXPAND cycle: temp = w[i-1], then w[i] = w[i-Nk] ^ f(temp).
  - If i mod Nk == 0: f = SubWord(RotWord(temp)) ^ {rcon, 24'h0}, and after the write rcon ← xtime(rcon), where xtime(x) = (x<<1) ^ (x[7] ? 8'h1B : 0).
  - If Nk == 8 and i mod 8 == 4: f = SubWord(temp), with no rotate and no rcon.
  - Otherwise f = temp.
- i mod Nk is tracked by a wrap counter (0..Nk-1), not a divider.
- Only one S-box instance (4 bytes) exists. Its input mux selects RotWord(temp) or temp.
- Read port:
  - rk_out is combinational from storage.
  - rk_idx > nr gives 128'h0.
  - Reads during EXPAND return the partially written contents; they are not qualified.
- Rekey while keys_valid=1: keys_valid drops on the handshake edge, and the old schedule is overwritten progressively.

## Timing
- Reset values:
  - state IDLE, key_ready=1, keys_valid=0, err=0, nr=0.
  - All storage words 0, so rk_out=0.
  - i=0, rcon=8'h01.
- Reset asserted mid-EXPAND: immediate return to the reset values; the partial schedule is discarded.
- Latency, with the handshake on edge T0:
  - EXPAND writes one word on each of edges T1..T(4*(Nr+1)-Nk).
  - keys_valid rises on that final edge: T40 for AES-128, T46 for AES-192, T52 for AES-256.
- err is set on the handshake edge of an illegal key and clears only on the next legal handshake. keys_valid stays 0 while err=1.
- key_valid held high in DONE causes immediate re-expansion; this is legal.

## Structure
- The shared package aes_pkg holds:
  - key_len encoding (enum) and the Nk/Nr lookup functions.
  - the xtime function and the FSM state enum.
  - RCON_INIT = 8'h01.
- One sub-module: the existing sbox, instantiated with NUM=4.
- Word storage is a flat register array of NUM_WORD_MAX x 32 bits.

## Test plan
- AES-128, key 2b7e151628aed2a6abf7158809cf4f3c, MSB-aligned → keys_valid after exactly 40 cycles; rk_idx=10 gives a word with w43=b6630ca6; rk_idx=0 returns the key.
- AES-192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b → keys_valid at 46 cycles; w51=01002202; nr=12; rk_idx=13 → 0.
- AES-256, key 603deb1015ca71be2b73aef0857d77811f3521..-style FIPS-197 A.3 key → keys_valid at 52 cycles; w59=706c631e (exercises the i mod 8 == 4 SubWord path); nr=14.
- key_len=3 handshake → err=1, keys_valid=0, key_ready=1 next cycle. A following legal AES-128 key → err=0 and a correct schedule.
- Reset pulse at cycle 20 of AES-256 expansion → all outputs return to reset values; a re-sent key completes correctly in 52 cycles.
- Rekey in DONE (AES-128 then AES-192, back-to-back) → keys_valid low for 46 cycles; the final schedule matches the AES-192 vector; key_ready low throughout EXPAND.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions for the key schedule and its S-box.
// Holds the key_len encoding with its Nk/Nr lookups, the GF(2^8) xtime helper,
// the key-schedule FSM state enum and the initial round constant.
package aes_pkg;

   typedef enum logic [1:0] {
      KeyLen128     = 2'd0,
      KeyLen192     = 2'd1,
      KeyLen256     = 2'd2,
      KeyLenIllegal = 2'd3
   } key_len_e;

   typedef enum logic [1:0] {
      StIdle,
      StExpand,
      StDone
   } state_e;

   localparam logic [7:0] RCON_INIT = 8'h01;

   // Key length in 32-bit words; 0 for the illegal encoding.
   function automatic logic [3:0] nk_of(input key_len_e kl);
      case (kl)
         KeyLen128: return 4'd4;
         KeyLen192: return 4'd6;
         KeyLen256: return 4'd8;
         default:   return 4'd0;
      endcase
   endfunction

   // Number of cipher rounds; 0 for the illegal encoding.
   function automatic logic [3:0] nr_of(input key_len_e kl);
      case (kl)
         KeyLen128: return 4'd10;
         KeyLen192: return 4'd12;
         KeyLen256: return 4'd14;
         default:   return 4'd0;
      endcase
   endfunction

   // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
   function automatic logic [7:0] xtime(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
   endfunction

endpackage

// File: rtl/sbox.sv
// AES forward S-box, NUM bytes wide, purely combinational.
// Each byte is computed as the GF(2^8) multiplicative inverse (x^254) followed
// by the AES affine transform, which avoids a 256-entry table per byte.
// Ports:
//   din  - NUM input bytes, byte g at din[8*g +: 8]
//   dout - NUM substituted bytes, same packing
module sbox
   import aes_pkg::*;
#(
   parameter int unsigned NUM = 4
) (
   input  logic [8*NUM-1:0] din,
   output logic [8*NUM-1:0] dout
);

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int k = 0; k < 8; k++) begin
         if (b[k]) p = p ^ aa;
         aa = xtime(aa);
      end
      return p;
   endfunction

   // x^254 = x^-1 for x != 0, and maps 0 to 0 as the S-box requires.
   function automatic logic [7:0] gf_inv(input logic [7:0] x);
      logic [7:0] x2, x3, x12, x15, x240;
      x2   = gf_mul(x, x);
      x3   = gf_mul(x2, x);
      x12  = gf_mul(gf_mul(x3, x3), gf_mul(x3, x3));
      x15  = gf_mul(x12, x3);
      x240 = gf_mul(x15, x15);
      x240 = gf_mul(x240, x240);
      x240 = gf_mul(x240, x240);
      x240 = gf_mul(x240, x240);
      return gf_mul(gf_mul(x240, x12), x2);
   endfunction

   function automatic logic [7:0] sbox_byte(input logic [7:0] x);
      logic [7:0] a;
      a = gf_inv(x);
      return a ^ {a[6:0], a[7]} ^ {a[5:0], a[7:6]} ^ {a[4:0], a[7:5]} ^ {a[3:0], a[7:4]}
             ^ 8'h63;
   endfunction

   for (genvar g = 0; g < NUM; g++) begin : g_byte
      assign dout[8*g +: 8] = sbox_byte(din[8*g +: 8]);
   end

endmodule

// File: rtl/key_schedule_iter.sv
// Iterative AES-128/192/256 key schedule, one expanded word per clock.
// A single 4-byte S-box is shared between the RotWord and plain SubWord steps.
// All words live in a flat register file read through a random-access port.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   key_valid   - key presented; accepted when key_ready is also high
//   key_ready   - high in IDLE and DONE
//   key_len     - 0=128, 1=192, 2=256, 3=illegal
//   key_in      - key, MSB-aligned (w0 at the top 32 bits)
//   keys_valid  - complete schedule stored
//   err         - last accepted key_len was illegal or too long
//   nr          - round count of the stored schedule
//   rk_idx      - round-key index to read
//   rk_out      - {w[4k], w[4k+1], w[4k+2], w[4k+3]}, zero if rk_idx > nr
module key_schedule_iter
   import aes_pkg::*;
#(
   parameter int unsigned MAX_LEN_KEY = 256
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   key_valid,
   output logic                   key_ready,
   input  logic [1:0]             key_len,
   input  logic [MAX_LEN_KEY-1:0] key_in,
   output logic                   keys_valid,
   output logic                   err,
   output logic [3:0]             nr,
   input  logic [3:0]             rk_idx,
   output logic [127:0]           rk_out
);

   localparam int unsigned MAX_WORDS_KEY = MAX_LEN_KEY / 32;
   localparam int unsigned NR_MAX        = MAX_WORDS_KEY + 6;
   localparam int unsigned NUM_WORD_MAX  = 4 * (NR_MAX + 1);

   state_e      state_q, state_d;
   logic [31:0] w_q [NUM_WORD_MAX];
   logic [31:0] w_d [NUM_WORD_MAX];
   logic [5:0]  i_q, i_d;
   logic [2:0]  mod_q, mod_d;   // i mod Nk, kept as a wrap counter
   logic [7:0]  rcon_q, rcon_d;
   logic [3:0]  nk_q, nk_d;
   logic [3:0]  nr_q, nr_d;
   logic        err_q, err_d;

   key_len_e    kl;
   logic [3:0]  nk_in;
   logic        legal;

   assign kl    = key_len_e'(key_len);
   assign nk_in = nk_of(kl);
   assign legal = (kl != KeyLenIllegal) && ((32'(nk_in) * 32'd32) <= MAX_LEN_KEY);

   // Expansion datapath.
   logic [5:0]  prev_idx, back_idx, last_idx;
   logic [31:0] temp, back, sbox_in, sbox_out, f_word;

   assign prev_idx = i_q - 6'd1;
   assign back_idx = i_q - {2'b00, nk_q};
   assign last_idx = {nr_q, 2'b00} + 6'd3;
   assign temp     = w_q[prev_idx];
   assign back     = w_q[back_idx];
   assign sbox_in  = (mod_q == 3'd0) ? {temp[23:0], temp[31:24]} : temp;

   sbox #(
      .NUM (4)
   ) u_sbox (
      .din  (sbox_in),
      .dout (sbox_out)
   );

   always_comb begin
      f_word = temp;
      if (mod_q == 3'd0) begin
         f_word = sbox_out ^ {rcon_q, 24'h0};
      end else if (nk_q == 4'd8 && mod_q == 3'd4) begin
         f_word = sbox_out;
      end
   end

   always_comb begin
      state_d = state_q;
      w_d     = w_q;
      i_d     = i_q;
      mod_d   = mod_q;
      rcon_d  = rcon_q;
      nk_d    = nk_q;
      nr_d    = nr_q;
      err_d   = err_q;
      case (state_q)
         StIdle, StDone: begin
            if (key_valid) begin
               if (legal) begin
                  for (int j = 0; j < int'(MAX_WORDS_KEY); j++) begin
                     if (j < int'(nk_in)) w_d[j] = key_in[MAX_LEN_KEY-1-32*j -: 32];
                  end
                  i_d     = 6'(nk_in);
                  mod_d   = 3'd0;
                  rcon_d  = RCON_INIT;
                  nk_d    = nk_in;
                  nr_d    = nr_of(kl);
                  err_d   = 1'b0;
                  state_d = StExpand;
               end else begin
                  err_d   = 1'b1;
                  state_d = StIdle;
               end
            end
         end
         StExpand: begin
            w_d[i_q] = back ^ f_word;
            i_d      = i_q + 6'd1;
            mod_d    = ({1'b0, mod_q} == nk_q - 4'd1) ? 3'd0 : mod_q + 3'd1;
            if (mod_q == 3'd0) rcon_d = xtime(rcon_q);
            if (i_q == last_idx) state_d = StDone;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         for (int j = 0; j < int'(NUM_WORD_MAX); j++) w_q[j] <= '0;
         i_q    <= '0;
         mod_q  <= '0;
         rcon_q <= RCON_INIT;
         nk_q   <= '0;
         nr_q   <= '0;
         err_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         for (int j = 0; j < int'(NUM_WORD_MAX); j++) w_q[j] <= w_d[j];
         i_q    <= i_d;
         mod_q  <= mod_d;
         rcon_q <= rcon_d;
         nk_q   <= nk_d;
         nr_q   <= nr_d;
         err_q  <= err_d;
      end
   end

   assign key_ready  = (state_q != StExpand);
   assign keys_valid = (state_q == StDone);
   assign err        = err_q;
   assign nr         = nr_q;

   // Read port: unqualified, so reads during EXPAND see partial contents.
   logic [5:0] base;
   assign base = {rk_idx, 2'b00};

   always_comb begin
      rk_out = '0;
      if (rk_idx <= nr_q && (32'(base) + 32'd3) < NUM_WORD_MAX) begin
         rk_out = {w_q[base], w_q[base + 6'd1], w_q[base + 6'd2], w_q[base + 6'd3]};
      end
   end

endmodule
